// File: rtl/dmem_master.sv
// Memory-stage bus initiator for a word-wide synchronous RAM without byte enables.
// Big-endian sub-word loads are extracted here; sub-word stores are done as read-modify-write.
module dmem_master #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_cs,
    output logic        ram_oe,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP, ERR} state_t;

    state_t      state_reg, state_next;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic [1:0]  lane_reg;
    logic [31:0] data_reg;
    logic [31:0] rdata_reg;
    logic [31:0] addr_reg;
    logic [2:0]  cnt_reg;

    logic        misaligned;
    logic [31:0] merged;
    logic [31:0] extracted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign misaligned = (req_size == 2'b11) ||
                        (req_size == 2'b01 && req_addr[0]) ||
                        (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned)
                        state_next = ERR;
                    else if (req_we && req_size == 2'b10)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:   state_next = WAIT;
            WAIT: if (cnt_reg == 3'd1) state_next = we_reg ? WR : RESP;
            WR:   state_next = RESP;
            RESP: state_next = IDLE;
            ERR:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane gi occupies bits [31-8*gi -: 8]; a half store covers lanes {0,1} or {2,3}.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic       LANE_HI  = (gi >= 2);
            localparam logic [1:0] LANE_IDX = 2'(gi);
            logic [7:0] new_byte;
            logic       hit;
            assign hit = (size_reg == 2'b00 && lane_reg == LANE_IDX) ||
                         (size_reg == 2'b01 && lane_reg[1] == LANE_HI);
            assign new_byte = (size_reg == 2'b01 && (gi % 2) == 0) ? data_reg[15:8] : data_reg[7:0];
            assign merged[31-8*gi -: 8] = hit ? new_byte : ram_dout[31-8*gi -: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = ram_dout[31:24];
        case (lane_reg)
            2'd0: byte_sel = ram_dout[31:24];
            2'd1: byte_sel = ram_dout[23:16];
            2'd2: byte_sel = ram_dout[15:8];
            2'd3: byte_sel = ram_dout[7:0];
            default: byte_sel = ram_dout[31:24];
        endcase
        half_sel = lane_reg[1] ? ram_dout[15:0] : ram_dout[31:16];
        case (size_reg)
            2'b00:   extracted = {{24{signed_reg & byte_sel[7]}}, byte_sel};
            2'b01:   extracted = {{16{signed_reg & half_sel[15]}}, half_sel};
            default: extracted = ram_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg     <= 1'b0;
            size_reg   <= 2'b00;
            signed_reg <= 1'b0;
            lane_reg   <= 2'b00;
            data_reg   <= 32'h0;
            rdata_reg  <= 32'h0;
            addr_reg   <= 32'h0;
            cnt_reg    <= 3'd0;
        end else begin
            if (state_reg == IDLE && req_valid) begin
                we_reg     <= req_we;
                size_reg   <= req_size;
                signed_reg <= req_signed;
                lane_reg   <= req_addr[1:0];
                data_reg   <= req_wdata;
                rdata_reg  <= 32'h0;
                addr_reg   <= {req_addr[31:2], 2'b00};
            end
            if (state_reg == RD)
                cnt_reg <= 3'(RD_LATENCY);
            if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg - 3'd1;
                // The read word is valid only on the final WAIT cycle.
                if (cnt_reg == 3'd1) begin
                    if (we_reg)
                        data_reg <= merged;
                    else
                        rdata_reg <= extracted;
                end
            end
        end
    end

    always_comb begin
        req_ready  = (state_reg == IDLE);
        ram_cs     = (state_reg == RD) || (state_reg == WR);
        ram_oe     = (state_reg == RD);
        ram_we     = (state_reg == WR);
        ram_addr   = addr_reg;
        ram_din    = (state_reg == WR) ? data_reg : 32'h0;
        resp_valid = (state_reg == RESP) || (state_reg == ERR);
        resp_err   = (state_reg == ERR);
        resp_rdata = (state_reg == RESP) ? rdata_reg : 32'h0;
    end

endmodule

// File: tb/tb_dmem_master.sv
// Bench for dmem_master: directed vector table, reset-abort sequence and random
// traffic checked against an arithmetic memory model; instances at RD_LATENCY 1 and 3.
module tb_dmem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid1, req_valid3;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready1, resp_valid1, resp_err1, ram_cs1, ram_oe1, ram_we1;
    logic [31:0] resp_rdata1, ram_addr1, ram_din1, ram_dout1;
    logic        req_ready3, resp_valid3, resp_err3, ram_cs3, ram_oe3, ram_we3;
    logic [31:0] resp_rdata3, ram_addr3, ram_din3, ram_dout3;

    logic        bd_we1, bd_we3;
    logic [9:0]  bd_addr;
    logic [31:0] bd_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_master #(.RD_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1), .ram_cs(ram_cs1),
        .ram_oe(ram_oe1), .ram_we(ram_we1), .ram_addr(ram_addr1),
        .ram_din(ram_din1), .ram_dout(ram_dout1)
    );

    dmem_master #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid3),
        .resp_rdata(resp_rdata3), .resp_err(resp_err3), .ram_cs(ram_cs3),
        .ram_oe(ram_oe3), .ram_we(ram_we3), .ram_addr(ram_addr3),
        .ram_din(ram_din3), .ram_dout(ram_dout3)
    );

    // RAM models: data appears exactly RD_LATENCY cycles after the read-issue
    // cycle and is poisoned at every other time.
    logic [31:0] mem1 [1024];
    logic [31:0] mem3 [1024];
    logic [31:0] p1_d [4];
    logic [31:0] p3_d [4];
    logic [3:0]  p1_v = 4'b0, p3_v = 4'b0;

    always_ff @(posedge clk) begin
        if (bd_we1) mem1[bd_addr] <= bd_data;
        if (ram_cs1 && ram_we1) mem1[ram_addr1[11:2]] <= ram_din1;
        p1_d[0] <= mem1[ram_addr1[11:2]];
        p1_v[0] <= ram_cs1 && ram_oe1;
        for (int i = 1; i < 4; i++) begin
            p1_d[i] <= p1_d[i-1];
            p1_v[i] <= p1_v[i-1];
        end
    end
    assign ram_dout1 = p1_v[0] ? p1_d[0] : 32'hBAD0BAD0;

    always_ff @(posedge clk) begin
        if (bd_we3) mem3[bd_addr] <= bd_data;
        if (ram_cs3 && ram_we3) mem3[ram_addr3[11:2]] <= ram_din3;
        p3_d[0] <= mem3[ram_addr3[11:2]];
        p3_v[0] <= ram_cs3 && ram_oe3;
        for (int k = 1; k < 4; k++) begin
            p3_d[k] <= p3_d[k-1];
            p3_v[k] <= p3_v[k-1];
        end
    end
    assign ram_dout3 = p3_v[2] ? p3_d[2] : 32'hBAD3BAD3;

    typedef struct {
        int          inst;
        logic        we;
        logic [1:0]  size;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_rd;
        int          exp_wr;
        int          exp_resp;
        logic [31:0] exp_din;
    } vec_t;

    logic [31:0] model_mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic f_err(input logic [1:0] sz, input logic [1:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0);
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        int sh;
        if (sz == 2'd0) begin
            sh = 8 * (3 - int'(a));
            v = (w >> sh) & 32'hFF;
            if (sg && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            sh = 16 * (1 - int'(a[1]));
            v = (w >> sh) & 32'hFFFF;
            if (sg && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] f_store(input logic [31:0] old, input logic [1:0] a,
                                            input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] m;
        int sh;
        if (sz == 2'd2) return wd;
        if (sz == 2'd0) begin
            sh = 8 * (3 - int'(a));
            m = 32'hFF << sh;
        end else begin
            sh = 16 * (1 - int'(a[1]));
            m = 32'hFFFF << sh;
        end
        return (old & ~m) | ((wd << sh) & m);
    endfunction

    task automatic backdoor(input int inst, input logic [9:0] idx, input logic [31:0] val);
        @(negedge clk);
        bd_addr = idx;
        bd_data = val;
        if (inst == 1) bd_we1 = 1'b1; else bd_we3 = 1'b1;
        @(negedge clk);
        bd_we1 = 1'b0;
        bd_we3 = 1'b0;
    endtask

    // One request, observed cycle by cycle; cycle 1 is the cycle after the accept edge.
    task automatic run_txn(input vec_t v);
        int rd_c = 0, wr_c = 0, resp_c = 0;
        logic [31:0] rdata = 32'h0, din = 32'h0, waddr = 32'h0;
        logic err = 1'b0;
        logic s_cs, s_oe, s_we, s_rv, s_err, s_rdy;
        logic [31:0] s_rdata, s_din, s_addr;
        @(negedge clk);
        s_rdy = (v.inst == 1) ? req_ready1 : req_ready3;
        chk("req_ready_idle", {31'b0, s_rdy}, 32'h1);
        req_we = v.we;
        req_size = v.size;
        req_signed = v.sg;
        req_addr = v.addr;
        req_wdata = v.wdata;
        if (v.inst == 1) req_valid1 = 1'b1; else req_valid3 = 1'b1;
        @(posedge clk);
        #1;
        req_valid1 = 1'b0;
        req_valid3 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (v.inst == 1) begin
                s_cs = ram_cs1; s_oe = ram_oe1; s_we = ram_we1; s_rv = resp_valid1;
                s_err = resp_err1; s_rdata = resp_rdata1; s_din = ram_din1; s_addr = ram_addr1;
            end else begin
                s_cs = ram_cs3; s_oe = ram_oe3; s_we = ram_we3; s_rv = resp_valid3;
                s_err = resp_err3; s_rdata = resp_rdata3; s_din = ram_din3; s_addr = ram_addr3;
            end
            if (s_oe && s_we) chk("oe_we_exclusive", 32'h1, 32'h0);
            if (!s_rv) chk("rdata_zero_idle", s_rdata, 32'h0);
            if (s_cs && s_oe && rd_c == 0) rd_c = c;
            if (s_cs && s_we) begin
                wr_c = c;
                din = s_din;
                waddr = s_addr;
            end
            if (s_rv) begin
                resp_c = c;
                rdata = s_rdata;
                err = s_err;
                break;
            end
        end
        chk("resp_cycle", 32'(resp_c), 32'(v.exp_resp));
        chk("resp_rdata", rdata, v.exp_rdata);
        chk("resp_err", {31'b0, err}, {31'b0, v.exp_err});
        chk("read_cycle", 32'(rd_c), 32'(v.exp_rd));
        chk("write_cycle", 32'(wr_c), 32'(v.exp_wr));
        if (v.exp_wr != 0) begin
            chk("ram_din", din, v.exp_din);
            chk("write_addr", waddr, {v.addr[31:2], 2'b00});
        end
        $display("txn inst=%0d we=%0d size=%0d signed=%0d addr=%h wdata=%h -> rdata=%h err=%0d rd=%0d wr=%0d resp=%0d",
                 v.inst, v.we, v.size, v.sg, v.addr, v.wdata, rdata, err, rd_c, wr_c, resp_c);
    endtask

    vec_t vecs [19];
    vec_t rv;

    initial begin
        int quiet;
        rst = 1'b1;
        req_valid1 = 1'b0; req_valid3 = 1'b0;
        req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        bd_we1 = 1'b0; bd_we3 = 1'b0; bd_addr = 10'd0; bd_data = 32'h0;

        //          inst we sz  sg addr         wdata         exp_rdata     err rd wr rsp din
        vecs[0]  = '{1, 0, 2'd2, 0, 32'h100, 32'h0,        32'h8A3C5E71, 0, 1, 0, 3, 32'h0};
        vecs[1]  = '{1, 0, 2'd0, 1, 32'h100, 32'h0,        32'hFFFFFF8A, 0, 1, 0, 3, 32'h0};
        vecs[2]  = '{1, 0, 2'd0, 0, 32'h103, 32'h0,        32'h00000071, 0, 1, 0, 3, 32'h0};
        vecs[3]  = '{1, 0, 2'd1, 1, 32'h102, 32'h0,        32'h00005E71, 0, 1, 0, 3, 32'h0};
        vecs[4]  = '{1, 0, 2'd1, 0, 32'h100, 32'h0,        32'h00008A3C, 0, 1, 0, 3, 32'h0};
        vecs[5]  = '{1, 1, 2'd0, 0, 32'h101, 32'h000000FF, 32'h0,        0, 1, 3, 4, 32'h8AFF5E71};
        vecs[6]  = '{1, 0, 2'd2, 0, 32'h100, 32'h0,        32'h8AFF5E71, 0, 1, 0, 3, 32'h0};
        vecs[7]  = '{1, 1, 2'd2, 0, 32'h200, 32'hDEADBEEF, 32'h0,        0, 0, 1, 2, 32'hDEADBEEF};
        vecs[8]  = '{1, 0, 2'd2, 0, 32'h200, 32'h0,        32'hDEADBEEF, 0, 1, 0, 3, 32'h0};
        vecs[9]  = '{1, 1, 2'd1, 0, 32'h202, 32'h00001234, 32'h0,        0, 1, 3, 4, 32'hDEAD1234};
        vecs[10] = '{1, 0, 2'd0, 1, 32'h202, 32'h0,        32'h00000012, 0, 1, 0, 3, 32'h0};
        vecs[11] = '{1, 0, 2'd1, 1, 32'h200, 32'h0,        32'hFFFFDEAD, 0, 1, 0, 3, 32'h0};
        vecs[12] = '{1, 0, 2'd1, 1, 32'h101, 32'h0,        32'h0,        1, 0, 0, 1, 32'h0};
        vecs[13] = '{1, 1, 2'd2, 0, 32'h202, 32'h55555555, 32'h0,        1, 0, 0, 1, 32'h0};
        vecs[14] = '{1, 0, 2'd3, 0, 32'h100, 32'h0,        32'h0,        1, 0, 0, 1, 32'h0};
        vecs[15] = '{1, 0, 2'd0, 1, 32'h101, 32'h0,        32'hFFFFFFFF, 0, 1, 0, 3, 32'h0};
        vecs[16] = '{3, 0, 2'd2, 0, 32'h100, 32'h0,        32'h8A3C5E71, 0, 1, 0, 5, 32'h0};
        vecs[17] = '{3, 1, 2'd0, 0, 32'h102, 32'h00000011, 32'h0,        0, 1, 5, 6, 32'h8A3C1171};
        vecs[18] = '{3, 0, 2'd2, 0, 32'h100, 32'h0,        32'h8A3C1171, 0, 1, 0, 5, 32'h0};

        backdoor(1, 10'h040, 32'h8A3C5E71);
        backdoor(3, 10'h040, 32'h8A3C5E71);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready1}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid1}, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err1}, 32'h0);
        chk("rst_resp_rdata", resp_rdata1, 32'h0);
        chk("rst_ram_ctl", {29'b0, ram_cs1, ram_oe1, ram_we1}, 32'h0);
        chk("rst_ram_addr", ram_addr1, 32'h0);
        chk("rst_ram_din", ram_din1, 32'h0);
        chk("rst_req_ready3", {31'b0, req_ready3}, 32'h1);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) run_txn(vecs[i]);

        // Reset during WAIT of a halfword store: nothing may follow.
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 32'h100; req_wdata = 32'h0000ABCD;
        req_valid1 = 1'b1;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        @(negedge clk);
        chk("abort_rd_issued", {31'b0, ram_oe1}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_req_ready", {31'b0, req_ready1}, 32'h1);
        chk("abort_resp", {30'b0, resp_valid1, resp_err1}, 32'h0);
        chk("abort_rdata", resp_rdata1, 32'h0);
        chk("abort_ram_ctl", {29'b0, ram_cs1, ram_oe1, ram_we1}, 32'h0);
        chk("abort_ram_addr", ram_addr1, 32'h0);
        chk("abort_ram_din", ram_din1, 32'h0);
        quiet = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ram_cs1 || resp_valid1) quiet++;
        end
        chk("abort_quiet", 32'(quiet), 32'h0);
        $display("txn abort SH 0x100 during WAIT -> quiet_violations=%0d", quiet);
        rv = '{1, 0, 2'd2, 0, 32'h100, 32'h0, 32'h8AFF5E71, 0, 1, 0, 3, 32'h0};
        run_txn(rv);

        // Random traffic on the RD_LATENCY=1 instance over the low 1 KiB.
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = $urandom;
            backdoor(1, 10'(i), model_mem[i]);
        end
        for (int n = 0; n < 150; n++) begin
            int r;
            logic [31:0] a;
            logic [31:0] old;
            r = $urandom_range(0, 15);
            rv.inst = 1;
            rv.size = (r == 0) ? 2'd3 : 2'(r % 3);
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                if (rv.size == 2'd2) a = a & ~32'h3;
                else if (rv.size == 2'd1) a = a & ~32'h1;
            end
            rv.addr = a;
            rv.we = 1'($urandom_range(0, 1));
            rv.sg = 1'($urandom_range(0, 1));
            rv.wdata = $urandom;
            old = model_mem[a[9:2]];
            rv.exp_err = f_err(rv.size, a[1:0]);
            rv.exp_rdata = 32'h0;
            rv.exp_din = 32'h0;
            if (rv.exp_err) begin
                rv.exp_rd = 0; rv.exp_wr = 0; rv.exp_resp = 1;
            end else if (rv.we) begin
                rv.exp_din = f_store(old, a[1:0], rv.size, rv.wdata);
                model_mem[a[9:2]] = rv.exp_din;
                if (rv.size == 2'd2) begin
                    rv.exp_rd = 0; rv.exp_wr = 1; rv.exp_resp = 2;
                end else begin
                    rv.exp_rd = 1; rv.exp_wr = 3; rv.exp_resp = 4;
                end
            end else begin
                rv.exp_rdata = f_load(old, a[1:0], rv.size, rv.sg);
                rv.exp_rd = 1; rv.exp_wr = 0; rv.exp_resp = 3;
            end
            run_txn(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
